// File: rtl/lsu_unit_pkg.sv
// Shared types and constants for the load/store unit.
package lsu_unit_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT
    } lsu_fsm_t;

    typedef enum logic [1:0] {
        OP_NONE,
        OP_LOAD,
        OP_STORE
    } lsu_op_typ_t;

    typedef enum logic [2:0] {
        LSU_B,
        LSU_H,
        LSU_W,
        LSU_BU,
        LSU_HU
    } lsu_width_t;

    localparam logic [3:0] CAUSE_LD_MISALIGNED   = 4'd4;
    localparam logic [3:0] CAUSE_LD_ACCESS_FAULT = 4'd5;
    localparam logic [3:0] CAUSE_ST_MISALIGNED   = 4'd6;
    localparam logic [3:0] CAUSE_ST_ACCESS_FAULT = 4'd7;

    // Op as presented by the execute stage.
    typedef struct packed {
        lsu_op_typ_t op_typ;
        lsu_width_t  width;
        logic [31:0] addr;
        logic [31:0] wdata;
    } s_lsu_op;

    typedef struct packed {
        logic [3:0]  cause;
        logic [31:0] mtval;
    } s_trap_info;

    // Op captured in IDLE; store lanes/strobes are already formatted.
    typedef struct packed {
        logic        we;
        lsu_width_t  width;
        logic [31:0] addr;
        logic [4:0]  rd;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
    } s_lsu_req_t;

endpackage

// File: rtl/lsu_data_align.sv
// Byte-lane handling: store strobes/replication, load lane select and
// extension, and misalignment detection.
module lsu_data_align
    import lsu_unit_pkg::*;
(
    input  lsu_width_t  width,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata_lane,
    output logic [31:0] rdata_ext,
    output logic        misaligned
);

    logic [31:0] rdata_shift;

    // Decode lanes and extension for the selected access width.
    always_comb begin
        rdata_shift = rdata >> {addr_lo, 3'b000};
        wstrb       = 4'b0001 << addr_lo;
        wdata_lane  = {4{wdata[7:0]}};
        rdata_ext   = rdata;
        misaligned  = 1'b0;
        case (width)
            LSU_B: begin
                rdata_ext = {{24{rdata_shift[7]}}, rdata_shift[7:0]};
            end
            LSU_BU: begin
                rdata_ext = {24'h000000, rdata_shift[7:0]};
            end
            LSU_H: begin
                wstrb      = 4'b0011 << addr_lo;
                wdata_lane = {2{wdata[15:0]}};
                rdata_ext  = {{16{rdata_shift[15]}}, rdata_shift[15:0]};
                misaligned = addr_lo[0];
            end
            LSU_HU: begin
                wstrb      = 4'b0011 << addr_lo;
                wdata_lane = {2{wdata[15:0]}};
                rdata_ext  = {16'h0000, rdata_shift[15:0]};
                misaligned = addr_lo[0];
            end
            LSU_W: begin
                wstrb      = 4'b1111;
                wdata_lane = wdata;
                rdata_ext  = rdata;
                misaligned = |addr_lo;
            end
            default: begin
                misaligned = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/lsu_unit.sv
// Load/store unit: one op at a time on a single-outstanding req/rsp bus,
// backpressuring execute until the op completes.
module lsu_unit
    import lsu_unit_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int BUS_TIMEOUT = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  s_lsu_op           lsu_i,
    input  logic [4:0]        rd_addr_i,
    output logic              lsu_bp_o,
    output logic              req_valid_o,
    input  logic              req_ready_i,
    output logic [ADDR_W-1:0] req_addr_o,
    output logic              req_we_o,
    output logic [DATA_W-1:0] req_wdata_o,
    output logic [3:0]        req_wstrb_o,
    input  logic              rsp_valid_i,
    input  logic [DATA_W-1:0] rsp_data_i,
    input  logic              rsp_err_i,
    output logic              ld_valid_o,
    output logic [4:0]        ld_rd_addr_o,
    output logic [31:0]       ld_data_o,
    output logic              trap_o,
    output s_trap_info        trap_info_o
);

    // A zero timeout still needs a legal 1-bit counter.
    localparam int          CW      = (BUS_TIMEOUT > 0) ? $clog2(BUS_TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TMO_MAX = CW'(BUS_TIMEOUT);

    lsu_fsm_t   state;
    lsu_fsm_t   state_nxt;
    s_lsu_req_t cap;
    logic [CW-1:0] tmo_cnt;

    lsu_width_t  sel_width;
    logic [1:0]  sel_addr_lo;
    logic [3:0]  al_wstrb;
    logic [31:0] al_wdata;
    logic [31:0] al_rdata;
    logic        al_misaligned;

    logic op_valid;
    logic op_ok;
    logic op_bad;
    logic timeout;

    // The aligner sees the incoming op in IDLE and the captured op otherwise.
    assign sel_width   = (state == IDLE) ? lsu_i.width     : cap.width;
    assign sel_addr_lo = (state == IDLE) ? lsu_i.addr[1:0] : cap.addr[1:0];

    lsu_data_align u_align (
        .width      (sel_width),
        .addr_lo    (sel_addr_lo),
        .wdata      (lsu_i.wdata),
        .rdata      (rsp_data_i[31:0]),
        .wstrb      (al_wstrb),
        .wdata_lane (al_wdata),
        .rdata_ext  (al_rdata),
        .misaligned (al_misaligned)
    );

    assign op_valid = (lsu_i.op_typ == OP_LOAD) || (lsu_i.op_typ == OP_STORE);
    assign op_ok    = (state == IDLE) && op_valid && !al_misaligned;
    assign op_bad   = (state == IDLE) && op_valid && al_misaligned;
    assign timeout  = (BUS_TIMEOUT != 0) && (state == WAIT) && (tmo_cnt == TMO_MAX);

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Next state, bus request and backpressure; bp drops in the completing
    // cycle (response or timeout) so execute advances exactly once.
    always_comb begin
        state_nxt   = state;
        lsu_bp_o    = 1'b0;
        req_valid_o = 1'b0;
        req_addr_o  = '0;
        req_we_o    = 1'b0;
        req_wdata_o = '0;
        req_wstrb_o = 4'b0000;
        case (state)
            IDLE: begin
                if (op_ok) begin
                    lsu_bp_o  = 1'b1;
                    state_nxt = REQ;
                end
            end
            REQ: begin
                lsu_bp_o    = 1'b1;
                req_valid_o = 1'b1;
                req_addr_o  = ADDR_W'({cap.addr[31:2], 2'b00});
                req_we_o    = cap.we;
                req_wdata_o = DATA_W'(cap.wdata);
                req_wstrb_o = cap.wstrb;
                if (req_ready_i) state_nxt = WAIT;
            end
            WAIT: begin
                if (rsp_valid_i || timeout) state_nxt = IDLE;
                else                         lsu_bp_o  = 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Capture the accepted op; pure data, qualified by the FSM.
    always_ff @(posedge clk) begin
        if (op_ok) begin
            cap.we    <= (lsu_i.op_typ == OP_STORE);
            cap.width <= lsu_i.width;
            cap.addr  <= lsu_i.addr;
            cap.rd    <= rd_addr_i;
            cap.wstrb <= al_wstrb;
            cap.wdata <= al_wdata;
        end
    end

    // Bus timeout counter: cleared on request accept, saturating in WAIT.
    always_ff @(posedge clk) begin
        if (!rst) begin
            tmo_cnt <= '0;
        end else if (state == REQ && req_ready_i) begin
            tmo_cnt <= '0;
        end else if (state == WAIT && tmo_cnt != TMO_MAX) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    // Registered writeback and trap pulses.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ld_valid_o   <= 1'b0;
            ld_rd_addr_o <= 5'd0;
            ld_data_o    <= 32'd0;
            trap_o       <= 1'b0;
            trap_info_o  <= '0;
        end else begin
            ld_valid_o <= 1'b0;
            trap_o     <= 1'b0;
            if (op_bad) begin
                trap_o            <= 1'b1;
                trap_info_o.cause <= (lsu_i.op_typ == OP_STORE) ? CAUSE_ST_MISALIGNED
                                                                : CAUSE_LD_MISALIGNED;
                trap_info_o.mtval <= lsu_i.addr;
            end else if (state == WAIT && (rsp_valid_i ? rsp_err_i : timeout)) begin
                trap_o            <= 1'b1;
                trap_info_o.cause <= cap.we ? CAUSE_ST_ACCESS_FAULT : CAUSE_LD_ACCESS_FAULT;
                trap_info_o.mtval <= cap.addr;
            end else if (state == WAIT && rsp_valid_i && !cap.we) begin
                ld_valid_o   <= 1'b1;
                ld_rd_addr_o <= cap.rd;
                ld_data_o    <= al_rdata;
            end
        end
    end

endmodule

// File: tb/tb_lsu_unit.sv
// Scoreboard bench for lsu_unit: directed ops push expected bus requests and
// writeback/trap results; a monitor compares them as the DUT produces them.
module tb_lsu_unit;
    import lsu_unit_pkg::*;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
    } exp_req_t;

    typedef struct {
        logic        is_trap;
        logic [4:0]  rd;
        logic [31:0] data;
        logic [3:0]  cause;
        logic [31:0] mtval;
    } exp_out_t;

    logic        clk;
    logic        rst;
    s_lsu_op     lsu_i;
    logic [4:0]  rd_addr_i;
    logic        lsu_bp_o;
    logic        req_valid_o;
    logic        req_ready_i;
    logic [31:0] req_addr_o;
    logic        req_we_o;
    logic [31:0] req_wdata_o;
    logic [3:0]  req_wstrb_o;
    logic        rsp_valid_i;
    logic [31:0] rsp_data_i;
    logic        rsp_err_i;
    logic        ld_valid_o;
    logic [4:0]  ld_rd_addr_o;
    logic [31:0] ld_data_o;
    logic        trap_o;
    s_trap_info  trap_info_o;

    exp_req_t exp_req[$];
    exp_out_t exp_out[$];

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int last_ld_cyc = 0;

    logic [31:0] mem_data = 32'h0;
    logic        mem_err = 1'b0;
    logic        no_rsp = 1'b0;
    int          stall_cycles = 0;
    int          stale_tok = 0;

    lsu_unit dut (
        .clk          (clk),
        .rst          (rst),
        .lsu_i        (lsu_i),
        .rd_addr_i    (rd_addr_i),
        .lsu_bp_o     (lsu_bp_o),
        .req_valid_o  (req_valid_o),
        .req_ready_i  (req_ready_i),
        .req_addr_o   (req_addr_o),
        .req_we_o     (req_we_o),
        .req_wdata_o  (req_wdata_o),
        .req_wstrb_o  (req_wstrb_o),
        .rsp_valid_i  (rsp_valid_i),
        .rsp_data_i   (rsp_data_i),
        .rsp_err_i    (rsp_err_i),
        .ld_valid_o   (ld_valid_o),
        .ld_rd_addr_o (ld_rd_addr_o),
        .ld_data_o    (ld_data_o),
        .trap_o       (trap_o),
        .trap_info_o  (trap_info_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_req(input logic [31:0] a, input logic we, input logic [3:0] s, input logic [31:0] d);
        exp_req_t e;
        e.addr = a; e.we = we; e.wstrb = s; e.wdata = d;
        exp_req.push_back(e);
    endtask

    task automatic push_ld(input logic [4:0] rd, input logic [31:0] d);
        exp_out_t e;
        e.is_trap = 1'b0; e.rd = rd; e.data = d; e.cause = 4'd0; e.mtval = 32'd0;
        exp_out.push_back(e);
    endtask

    task automatic push_trap(input logic [3:0] c, input logic [31:0] mt);
        exp_out_t e;
        e.is_trap = 1'b1; e.rd = 5'd0; e.data = 32'd0; e.cause = c; e.mtval = mt;
        exp_out.push_back(e);
    endtask

    // Bus slave: optional ready stall per request, response the cycle after accept.
    initial begin
        int   st;
        int   stale_seen;
        logic acc;
        st = 0;
        stale_seen = 0;
        req_ready_i = 1'b1;
        rsp_valid_i = 1'b0;
        rsp_data_i  = 32'h0;
        rsp_err_i   = 1'b0;
        forever begin
            @(negedge clk);
            acc = req_valid_o && req_ready_i;
            @(posedge clk);
            #1;
            rsp_valid_i = 1'b0;
            rsp_err_i   = 1'b0;
            rsp_data_i  = 32'h0;
            if (acc && !no_rsp) begin
                rsp_valid_i = 1'b1;
                rsp_data_i  = mem_data;
                rsp_err_i   = mem_err;
            end else if (stale_tok != stale_seen) begin
                stale_seen  = stale_tok;
                rsp_valid_i = 1'b1;
                rsp_data_i  = 32'hBAD0BAD0;
            end
            if (req_valid_o) begin
                if (st < stall_cycles) begin
                    req_ready_i = 1'b0;
                    st++;
                end else begin
                    req_ready_i = 1'b1;
                end
            end else begin
                st = 0;
                req_ready_i = 1'b1;
            end
        end
    end

    // Monitor: compare every request cycle and every writeback/trap pulse.
    initial begin
        exp_req_t r;
        exp_out_t o;
        forever begin
            @(negedge clk);
            if (req_valid_o) begin
                check("bp_during_req", {31'd0, lsu_bp_o}, 32'd1);
                if (exp_req.size() == 0) begin
                    check("unexpected_req", {31'd0, req_valid_o}, 32'd0);
                end else begin
                    r = exp_req[0];
                    check("req_addr", req_addr_o, r.addr);
                    check("req_we", {31'd0, req_we_o}, {31'd0, r.we});
                    if (r.we) begin
                        check("req_wstrb", {28'd0, req_wstrb_o}, {28'd0, r.wstrb});
                        check("req_wdata", req_wdata_o, r.wdata);
                    end
                    if (req_ready_i) void'(exp_req.pop_front());
                end
            end
            if (ld_valid_o || trap_o) begin
                if (exp_out.size() == 0) begin
                    check("unexpected_ld_valid", {31'd0, ld_valid_o}, 32'd0);
                    check("unexpected_trap", {31'd0, trap_o}, 32'd0);
                end else begin
                    o = exp_out.pop_front();
                    check("trap_o", {31'd0, trap_o}, {31'd0, o.is_trap});
                    check("ld_valid_o", {31'd0, ld_valid_o}, {31'd0, !o.is_trap});
                    if (o.is_trap) begin
                        check("trap_cause", {28'd0, trap_info_o.cause}, {28'd0, o.cause});
                        check("trap_mtval", trap_info_o.mtval, o.mtval);
                    end else begin
                        check("ld_data", ld_data_o, o.data);
                        check("ld_rd", {27'd0, ld_rd_addr_o}, {27'd0, o.rd});
                        last_ld_cyc = cyc;
                    end
                end
            end
        end
    end

    task automatic check_quiet(input string tag);
        check({tag, "_bp"},        {31'd0, lsu_bp_o},    32'd0);
        check({tag, "_req_valid"}, {31'd0, req_valid_o}, 32'd0);
        check({tag, "_req_addr"},  req_addr_o,           32'd0);
        check({tag, "_req_we"},    {31'd0, req_we_o},    32'd0);
        check({tag, "_req_wdata"}, req_wdata_o,          32'd0);
        check({tag, "_req_wstrb"}, {28'd0, req_wstrb_o}, 32'd0);
        check({tag, "_ld_valid"},  {31'd0, ld_valid_o},  32'd0);
        check({tag, "_ld_rd"},     {27'd0, ld_rd_addr_o}, 32'd0);
        check({tag, "_ld_data"},   ld_data_o,            32'd0);
        check({tag, "_trap"},      {31'd0, trap_o},      32'd0);
        check({tag, "_trap_info"}, trap_info_o.mtval,    32'd0);
    endtask

    // Present an op (caller is just past a rising edge) and hold it until bp is low.
    task automatic issue(input lsu_op_typ_t typ, input lsu_width_t w, input logic [31:0] a,
                         input logic [31:0] d, input logic [4:0] rd,
                         output int bp_cycles, output int at_cyc);
        bit done;
        lsu_i = '{op_typ: typ, width: w, addr: a, wdata: d};
        rd_addr_i = rd;
        at_cyc = cyc;
        bp_cycles = 0;
        done = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (!lsu_bp_o) begin
                done = 1'b1;
                break;
            end
            bp_cycles++;
            @(posedge clk);
            #1;
        end
        if (!done) check("bp_release_timeout", {31'd0, lsu_bp_o}, 32'd0);
        @(posedge clk);
        #1;
        lsu_i = '{op_typ: OP_NONE, width: LSU_B, addr: 32'd0, wdata: 32'd0};
        rd_addr_i = 5'd0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_out.size() != 0 || exp_req.size() != 0) && n < 100) begin
            @(posedge clk);
            n++;
        end
        if (n >= 100) check("drain_timeout", exp_out.size() + exp_req.size(), 32'd0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    typedef struct {
        lsu_op_typ_t typ;
        lsu_width_t  w;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] mem;
        logic [31:0] exp;
        logic [3:0]  strb;
    } vec_t;

    initial begin
        int bpc;
        int at;
        vec_t v[8];

        rst = 1'b0;
        lsu_i = '{op_typ: OP_NONE, width: LSU_B, addr: 32'd0, wdata: 32'd0};
        rd_addr_i = 5'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_quiet("reset");
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;

        // LW with latency and backpressure length
        mem_data = 32'hDEADBEEF;
        push_req(32'h1000, 1'b0, 4'b1111, 32'h0);
        push_ld(5'd5, 32'hDEADBEEF);
        issue(OP_LOAD, LSU_W, 32'h1000, 32'h0, 5'd5, bpc, at);
        check("lw_bp_cycles", bpc, 32'd2);
        drain();
        check("lw_latency", last_ld_cyc - at, 32'd3);

        // Directed loads and stores: exp is load result or store wdata lanes
        v[0] = '{OP_LOAD,  LSU_B,  32'h1003, 32'h0,        32'h80FF0000, 32'hFFFFFF80, 4'b1000};
        v[1] = '{OP_LOAD,  LSU_BU, 32'h1003, 32'h0,        32'h80FF0000, 32'h00000080, 4'b1000};
        v[2] = '{OP_LOAD,  LSU_H,  32'h1002, 32'h0,        32'h80FF0000, 32'hFFFF80FF, 4'b1100};
        v[3] = '{OP_LOAD,  LSU_HU, 32'h1000, 32'h0,        32'h80FF8001, 32'h00008001, 4'b0011};
        v[4] = '{OP_LOAD,  LSU_B,  32'h1001, 32'h0,        32'h12345678, 32'h00000056, 4'b0010};
        v[5] = '{OP_STORE, LSU_H,  32'h2002, 32'h1234ABCD, 32'h0,        32'hABCDABCD, 4'b1100};
        v[6] = '{OP_STORE, LSU_B,  32'h2001, 32'h000000A5, 32'h0,        32'hA5A5A5A5, 4'b0010};
        v[7] = '{OP_STORE, LSU_W,  32'h2004, 32'hCAFEF00D, 32'h0,        32'hCAFEF00D, 4'b1111};
        for (int i = 0; i < 8; i++) begin
            mem_data = v[i].mem;
            push_req({v[i].addr[31:2], 2'b00}, v[i].typ == OP_STORE, v[i].strb, v[i].exp);
            if (v[i].typ == OP_LOAD) push_ld(5'(i + 10), v[i].exp);
            issue(v[i].typ, v[i].w, v[i].addr, v[i].wdata, 5'(i + 10), bpc, at);
            check("vec_bp_cycles", bpc, 32'd2);
            drain();
        end

        // Misaligned: trap only, no bus traffic, no backpressure
        push_trap(CAUSE_LD_MISALIGNED, 32'h3001);
        issue(OP_LOAD, LSU_W, 32'h3001, 32'h0, 5'd4, bpc, at);
        check("mis_lw_bp", bpc, 32'd0);
        drain();
        push_trap(CAUSE_ST_MISALIGNED, 32'h3003);
        issue(OP_STORE, LSU_H, 32'h3003, 32'h5555, 5'd0, bpc, at);
        check("mis_sh_bp", bpc, 32'd0);
        drain();
        push_trap(CAUSE_LD_MISALIGNED, 32'h3001);
        issue(OP_LOAD, LSU_HU, 32'h3001, 32'h0, 5'd4, bpc, at);
        check("mis_lhu_bp", bpc, 32'd0);
        drain();

        // Request stall of 5 cycles: fields checked every REQ cycle
        stall_cycles = 5;
        mem_data = 32'h11223344;
        push_req(32'h4000, 1'b0, 4'b1111, 32'h0);
        push_ld(5'd7, 32'h11223344);
        issue(OP_LOAD, LSU_W, 32'h4000, 32'h0, 5'd7, bpc, at);
        check("stall_bp_cycles", bpc, 32'd7);
        drain();
        stall_cycles = 0;

        // Bus errors
        mem_err = 1'b1;
        push_req(32'h5000, 1'b0, 4'b1111, 32'h0);
        push_trap(CAUSE_LD_ACCESS_FAULT, 32'h5000);
        issue(OP_LOAD, LSU_W, 32'h5000, 32'h0, 5'd9, bpc, at);
        drain();
        push_req(32'h5008, 1'b1, 4'b1111, 32'h600DF00D);
        push_trap(CAUSE_ST_ACCESS_FAULT, 32'h5008);
        issue(OP_STORE, LSU_W, 32'h5008, 32'h600DF00D, 5'd0, bpc, at);
        drain();
        mem_err = 1'b0;

        // No response at all: timeout forces an access fault
        no_rsp = 1'b1;
        push_req(32'h6000, 1'b0, 4'b1111, 32'h0);
        push_trap(CAUSE_LD_ACCESS_FAULT, 32'h6000);
        issue(OP_LOAD, LSU_W, 32'h6000, 32'h0, 5'd2, bpc, at);
        drain();

        // Reset while waiting for a response
        push_req(32'h7000, 1'b0, 4'b1111, 32'h0);
        lsu_i = '{op_typ: OP_LOAD, width: LSU_W, addr: 32'h7000, wdata: 32'h0};
        rd_addr_i = 5'd3;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        lsu_i = '{op_typ: OP_NONE, width: LSU_B, addr: 32'd0, wdata: 32'd0};
        rd_addr_i = 5'd0;
        @(posedge clk);
        #1;
        @(negedge clk);
        check_quiet("midop_reset");
        @(posedge clk);
        #1;
        rst = 1'b1;
        no_rsp = 1'b0;
        stale_tok = stale_tok + 1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("stale_ld_valid", {31'd0, ld_valid_o}, 32'd0);
            check("stale_trap", {31'd0, trap_o}, 32'd0);
            check("stale_bp", {31'd0, lsu_bp_o}, 32'd0);
        end
        @(posedge clk);
        #1;

        // Recovery after reset
        mem_data = 32'hA5A55A5A;
        push_req(32'h1000, 1'b0, 4'b1111, 32'h0);
        push_ld(5'd1, 32'hA5A55A5A);
        issue(OP_LOAD, LSU_W, 32'h1000, 32'h0, 5'd1, bpc, at);
        drain();

        check("req_queue_empty", exp_req.size(), 32'd0);
        check("out_queue_empty", exp_out.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
